// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor. A chain of SLICE full-adder cells is reused
// over WIDTH/SLICE clock cycles; the carry between steps is kept in a register.
// Handshake: start (sampled in IDLE) -> busy during RUN -> one-cycle done.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS  = WIDTH / SLICE;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [SLICE-1:0]  slice_sum;
  logic [SLICE:0]    slice_c;
  logic [WIDTH-1:0]  res_next;

  // One-bit full adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Ripple the current low SLICE bits of A and B through the full-adder chain.
  always_comb begin
    slice_sum  = '0;
    slice_c    = '0;
    slice_c[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      {slice_c[i+1], slice_sum[i]} = full_add(a_q[i], b_q[i], slice_c[i]);
    end
    // New result bits enter at the MSB end so the LSB slice lands at bit 0 after STEPS shifts.
    res_next = (res_q >> SLICE) | (WIDTH'(slice_sum) << (WIDTH - SLICE));
  end

  // Next-state and datapath control for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    step_d  = step_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtract as a + ~b + 1: invert B here, inject the +1 as the first carry-in.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          step_d  = '0;
          res_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = slice_c[SLICE];
        res_d   = res_next;
        step_d  = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) begin
          // The final slice holds the MSB cell, so its carries give cout and ovf.
          sum_d   = res_next;
          cout_d  = slice_c[SLICE];
          ovf_d   = slice_c[SLICE] ^ slice_c[SLICE-1];
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, including results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
